// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: state encoding, frame constants and helpers shared by the UART
// transmitter and the future receiver.
package uart_pkg;

    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_START  = 3'd1;
    localparam logic [2:0] UART_ST_DATA   = 3'd2;
    localparam logic [2:0] UART_ST_PARITY = 3'd3;
    localparam logic [2:0] UART_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = UART_ST_IDLE,
        ST_START  = UART_ST_START,
        ST_DATA   = UART_ST_DATA,
        ST_PARITY = UART_ST_PARITY,
        ST_STOP   = UART_ST_STOP
    } uart_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
`timescale 1ns/1ps
// uart_baud_counter: free-running 0..CLKS_PER_BIT-1 counter with a one-cycle
// bit-end tick at the last count; held at zero while clear_i is high.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count register: wraps at CNT_LAST so ticks stay evenly spaced.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    assign tick_o = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_byte_transmitter.sv
`timescale 1ns/1ps
// uart_byte_transmitter: LSB-first 8-N-1 / 8-N-2 serializer with busy handshake.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_byte_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       new_tx_data_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_busy_o,
    output logic       tx_o
);

    localparam logic [2:0] LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST    = 1'(STOP_BITS - 1);

    uart_state_e               state_r, state_s;
    logic [UART_DATA_BITS-1:0] shift_r, shift_s;
    logic [2:0]                bit_idx_r, bit_idx_s;
    logic                      stop_cnt_r, stop_cnt_s;
    logic                      tx_r, tx_s;
    logic                      busy_r, busy_s;
    logic                      tick_s;
    logic                      clear_s;
`ifdef UART_TX_PARITY_EN
    logic                      parity_r, parity_s;
`endif

    // The counter idles at zero so the first bit period starts on acceptance.
    assign clear_s = (state_r == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear_s),
        .tick_o (tick_s)
    );

    // Next-state, datapath and output decode; outputs come from the next state
    // so the registered line changes on the same edge as the state.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_idx_s  = bit_idx_r;
        stop_cnt_s = stop_cnt_r;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (new_tx_data_i) begin
                    shift_s    = tx_byte_i;
                    bit_idx_s  = 3'd0;
                    stop_cnt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_s   = uart_even_parity(tx_byte_i);
`endif
                    state_s    = ST_START;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s   = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == LAST_BIT_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (stop_cnt_r == STOP_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        stop_cnt_s = stop_cnt_r + 1'b1;
                        state_s    = ST_STOP;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            stop_cnt_r <= stop_cnt_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign tx_o      = tx_r;
    assign tx_busy_o = busy_r;

endmodule
